bit_scan_scheduler: RTL

BIT_SCAN_SCHEDULER -- requirements
Module: bit_scan_scheduler

---
 rtl/bit_scan_scheduler.sv | 105 ++++++++++
 1 files changed

// File: rtl/bit_scan_scheduler.sv
// bit_scan_scheduler: captures a bit mask and issues the index of each set
// bit, lowest first, over a valid/ready handshake. One position per cycle
// when the consumer is always ready; abort drops the remaining positions.
module bit_scan_scheduler #(
    parameter int N  = 10,
    parameter int W  = $clog2(N),
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  mask_in,
    input  logic          abort,
    input  logic          pos_ready,
    output logic          pos_valid,
    output logic [W-1:0]  pos_out,
    output logic          pos_last,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [N-1:0]  pending_q, pending_d;
    logic [CW-1:0] count_q, count_d;

    logic [N-1:0]  pend_m1;
    logic [N-1:0]  pend_iso;
    logic [N-1:0]  pend_rest;
    logic [W-1:0]  pos_enc;
    logic          hs;

    // Isolate the lowest pending bit; the remainder is what is left after it is issued.
    always_comb begin
        pend_m1   = pending_q - ONE;
        pend_iso  = pending_q & ~pend_m1;
        pend_rest = pending_q & pend_m1;
    end

    // One-hot to binary encode of the isolated bit (zero when nothing pending).
    always_comb begin
        pos_enc = '0;
        for (int i = 0; i < N; i++) begin
            if (pend_iso[i]) pos_enc = pos_enc | W'(i);
        end
    end

    assign pos_out   = pos_enc;
    assign pos_valid = (state_q == SCAN) & ~abort;
    assign pos_last  = (state_q == SCAN) & (pend_rest == '0);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign count_out = count_q;
    assign hs        = pos_valid & pos_ready;

    // Next-state: load on start in IDLE, retire one bit per handshake, abort drops everything.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pending_d = mask_in;
                    count_d   = '0;
                    state_d   = (mask_in != '0) ? SCAN : DONE;
                end
            end
            SCAN: begin
                if (abort) begin
                    pending_d = '0;
                    state_d   = IDLE;
                end else if (hs) begin
                    pending_d = pend_rest;
                    count_d   = count_q + CW'(1);
                    if (pos_last) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

endmodule
